// File: rtl/mux_etapa_n.sv
// Pipelined N-input multiplexer with stall/flush control and out-of-range select flag.
// Stage 1 registers the mux result; an optional stage 2 copies stage 1.
module mux_etapa_n #(
    parameter int ANCHO    = 32,
    parameter int ENTRADAS = 4,
    parameter int ETAPAS   = 1,
    localparam int SEL_W   = (ENTRADAS > 1) ? $clog2(ENTRADAS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SEL_W-1:0]          sel,
    input  logic [ENTRADAS*ANCHO-1:0] entradas,
    input  logic                      valido_in,
    input  logic                      stall,
    input  logic                      flush,
    output logic [ANCHO-1:0]          salida,
    output logic                      valido_out,
    output logic                      error_sel
);

    logic [ANCHO-1:0] dato_mux;
    logic             acierto;
    logic             err_mux;

    always_comb begin
        dato_mux = '0;
        acierto  = 1'b0;
        for (int k = 0; k < ENTRADAS; k++) begin
            if (sel == SEL_W'(k)) begin
                dato_mux = entradas[k*ANCHO +: ANCHO];
                acierto  = 1'b1;
            end
        end
        // err only ever set for a qualified entry, so error_sel implies valido_out
        err_mux = valido_in & ~acierto;
    end

    // ---- stage 1: capture mux result ----
    logic [ANCHO-1:0] dato_p1;
    logic             vld_p1;
    logic             err_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dato_p1 <= '0;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
        end else if (flush) begin
            dato_p1 <= '0;
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
        end else if (!stall) begin
            dato_p1 <= dato_mux;
            vld_p1  <= valido_in;
            err_p1  <= err_mux;
        end
    end

    // ---- stage 2 (optional): copy of stage 1 ----
    if (ETAPAS == 2) begin : g_dos
        logic [ANCHO-1:0] dato_p2;
        logic             vld_p2;
        logic             err_p2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dato_p2 <= '0;
                vld_p2  <= 1'b0;
                err_p2  <= 1'b0;
            end else if (flush) begin
                dato_p2 <= '0;
                vld_p2  <= 1'b0;
                err_p2  <= 1'b0;
            end else if (!stall) begin
                dato_p2 <= dato_p1;
                vld_p2  <= vld_p1;
                err_p2  <= err_p1;
            end
        end

        assign salida     = dato_p2;
        assign valido_out = vld_p2;
        assign error_sel  = err_p2;
    end else begin : g_uno
        assign salida     = dato_p1;
        assign valido_out = vld_p1;
        assign error_sel  = err_p1;
    end

endmodule

// File: tb/tb_mux_etapa_n.sv
// Directed bench for mux_etapa_n: three instances (4/1, 3/2 and 2/1 inputs/stages)
// share control inputs; each check looks at the instance relevant to the scenario.
module tb_mux_etapa_n;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         vin, stall, flush;
    logic [1:0]   sel;
    logic [127:0] ent;

    logic [31:0] sa, sb, sc;
    logic        va, vb, vc, ea, eb, ec;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_etapa_n #(.ANCHO(32), .ENTRADAS(4), .ETAPAS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .sel(sel), .entradas(ent),
        .valido_in(vin), .stall(stall), .flush(flush),
        .salida(sa), .valido_out(va), .error_sel(ea));

    mux_etapa_n #(.ANCHO(32), .ENTRADAS(3), .ETAPAS(2)) u_b (
        .clk(clk), .rst_n(rst_n), .sel(sel), .entradas(ent[95:0]),
        .valido_in(vin), .stall(stall), .flush(flush),
        .salida(sb), .valido_out(vb), .error_sel(eb));

    mux_etapa_n #(.ANCHO(32), .ENTRADAS(2), .ETAPAS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .sel(sel[0]), .entradas(ent[63:0]),
        .valido_in(vin), .stall(stall), .flush(flush),
        .salida(sc), .valido_out(vc), .error_sel(ec));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic        vin;
        logic        stall;
        logic        flush;
        logic [31:0] a_dat;
        logic        a_v;
        logic        a_e;
        logic [31:0] b_dat;
        logic        b_v;
        logic        b_e;
    } vec_t;

    vec_t tbl [14];

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0001;
    localparam logic [31:0] D2 = 32'hA5A5_0001;
    localparam logic [31:0] D3 = 32'h4444_0003;
    localparam logic [31:0] X  = 32'hCAFE_0000;
    localparam logic [31:0] Y  = 32'hBEEF_0001;

    initial begin
        //            sel  vin   stl   fls   A: dat  v     e     B: dat  v     e
        tbl[0]  = '{2'd2, 1'b1, 1'b0, 1'b0, D2,    1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[1]  = '{2'd0, 1'b0, 1'b0, 1'b0, D0,    1'b0, 1'b0, D2,    1'b1, 1'b0};
        tbl[2]  = '{2'd1, 1'b1, 1'b0, 1'b0, D1,    1'b1, 1'b0, D0,    1'b0, 1'b0};
        tbl[3]  = '{2'd3, 1'b1, 1'b0, 1'b0, D3,    1'b1, 1'b0, D1,    1'b1, 1'b0};
        tbl[4]  = '{2'd0, 1'b1, 1'b1, 1'b0, D3,    1'b1, 1'b0, D1,    1'b1, 1'b0};
        tbl[5]  = '{2'd0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[6]  = '{2'd1, 1'b1, 1'b0, 1'b0, D1,    1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[7]  = '{2'd0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[8]  = '{2'd2, 1'b1, 1'b0, 1'b0, D2,    1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[9]  = '{2'd0, 1'b1, 1'b1, 1'b0, D2,    1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[10] = '{2'd0, 1'b0, 1'b0, 1'b0, D0,    1'b0, 1'b0, D2,    1'b1, 1'b0};
        tbl[11] = '{2'd3, 1'b1, 1'b0, 1'b0, D3,    1'b1, 1'b0, D0,    1'b0, 1'b0};
        tbl[12] = '{2'd0, 1'b0, 1'b0, 1'b0, D0,    1'b0, 1'b0, 32'h0, 1'b1, 1'b1};
        tbl[13] = '{2'd0, 1'b0, 1'b0, 1'b0, D0,    1'b0, 1'b0, D0,    1'b0, 1'b0};

        rst_n = 1'b1;
        vin   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        sel   = 2'd0;
        ent   = {D3, D2, D1, D0};

        // Reset asserted without any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_a_dat", sa, 32'h0);
        chk("rst_a_v", {31'b0, va}, 32'h0);
        chk("rst_a_e", {31'b0, ea}, 32'h0);
        chk("rst_b_dat", sb, 32'h0);
        chk("rst_b_v", {31'b0, vb}, 32'h0);
        chk("rst_b_e", {31'b0, eb}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Table: A (4 inputs, 1 stage) and B (3 inputs, 2 stages) in lockstep
        for (int i = 0; i < 14; i++) begin
            sel   = tbl[i].sel;
            vin   = tbl[i].vin;
            stall = tbl[i].stall;
            flush = tbl[i].flush;
            tick();
            chk($sformatf("vec%0d_a_dat", i), sa, tbl[i].a_dat);
            chk($sformatf("vec%0d_a_v", i), {31'b0, va}, {31'b0, tbl[i].a_v});
            chk($sformatf("vec%0d_a_e", i), {31'b0, ea}, {31'b0, tbl[i].a_e});
            chk($sformatf("vec%0d_b_dat", i), sb, tbl[i].b_dat);
            chk($sformatf("vec%0d_b_v", i), {31'b0, vb}, {31'b0, tbl[i].b_v});
            chk($sformatf("vec%0d_b_e", i), {31'b0, eb}, {31'b0, tbl[i].b_e});
        end
        stall = 1'b0;
        flush = 1'b0;

        // Stall holding two entries in B
        flush = 1'b1; vin = 1'b0;
        tick();
        flush = 1'b0;
        ent = {D3, D2, Y, X};
        sel = 2'd0; vin = 1'b1;
        tick();
        sel = 2'd1; vin = 1'b1;
        tick();
        chk("stall_pre_dat", sb, X);
        chk("stall_pre_v", {31'b0, vb}, 32'h1);
        stall = 1'b1; sel = 2'd2; vin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_dat", i), sb, X);
            chk($sformatf("stall%0d_v", i), {31'b0, vb}, 32'h1);
        end
        stall = 1'b0; vin = 1'b0;
        tick();
        chk("stall_post_dat", sb, Y);
        chk("stall_post_v", {31'b0, vb}, 32'h1);
        tick();
        chk("stall_drop_v", {31'b0, vb}, 32'h0);

        // Flush beats stall with two entries in flight
        sel = 2'd0; vin = 1'b1;
        tick();
        sel = 2'd1; vin = 1'b1;
        tick();
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("flush_dat", sb, 32'h0);
        chk("flush_v", {31'b0, vb}, 32'h0);
        chk("flush_e", {31'b0, eb}, 32'h0);
        stall = 1'b0; flush = 1'b0; vin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("flush_after%0d_v", i), {31'b0, vb}, 32'h0);
        end

        // Asynchronous reset mid-stream on A
        ent = {D3, D2, D1, D0};
        sel = 2'd2; vin = 1'b1;
        tick();
        chk("arst_pre_dat", sa, D2);
        chk("arst_pre_v", {31'b0, va}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dat", sa, 32'h0);
        chk("arst_v", {31'b0, va}, 32'h0);
        #1 rst_n = 1'b1;
        sel = 2'd1; vin = 1'b1;
        tick();
        chk("arst_first_dat", sa, D1);
        chk("arst_first_v", {31'b0, va}, 32'h1);
        vin = 1'b0;
        tick();
        chk("arst_idle_v", {31'b0, va}, 32'h0);

        // Back-to-back toggling select on C (2 inputs)
        ent = {64'h0, 32'h1, 32'h2};
        vin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = (i % 2 == 1) ? 2'd1 : 2'd0;
            tick();
            chk($sformatf("b2b%0d_dat", i), sc, (i % 2 == 1) ? 32'h1 : 32'h2);
            chk($sformatf("b2b%0d_v", i), {31'b0, vc}, 32'h1);
            chk($sformatf("b2b%0d_e", i), {31'b0, ec}, 32'h0);
        end
        vin = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_etapa_n.md
MUX_ETAPA_N -- requirements
Module: mux_etapa_n

Interface
REQ-001 The block SHALL expose parameter ANCHO, default 32, giving the data width in bits of each input and of the output.
REQ-002 The block SHALL expose parameter ENTRADAS, default 4, giving the number of data inputs; legal range 2..16.
REQ-003 The block SHALL expose parameter ETAPAS, default 1, giving the pipeline depth; legal values 1 or 2.
REQ-004 The block SHALL derive localparam SEL_W = clog2(ENTRADAS), with a minimum of 1.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 sel  input  SEL_W  index of the input to forward.
REQ-008 entradas  input  ENTRADAS*ANCHO  packed data inputs; input k occupies bits [k*ANCHO +: ANCHO].
REQ-009 valido_in  input  1  qualifies sel and entradas in the current cycle.
REQ-010 stall  input  1  holds the whole pipeline.
REQ-011 flush  input  1  kills all in-flight entries.
REQ-012 salida  output  ANCHO  registered selected data.
REQ-013 valido_out  output  1  qualifies salida.
REQ-014 error_sel  output  1  registered flag: the entry now at the output had an out-of-range sel.

Function
REQ-015 Each stage SHALL hold {data, valid, err}. Stage 1 captures the mux result of sel/entradas. With ETAPAS=2, stage 2 copies stage 1. The outputs SHALL be driven only by the last stage.
REQ-016 Latency SHALL be exactly ETAPAS cycles from the valido_in edge to the matching valido_out, absent stall and flush.
REQ-017 If sel < ENTRADAS, stage 1 data SHALL be entradas[sel*ANCHO +: ANCHO] and err SHALL be 0.
REQ-018 If sel >= ENTRADAS, stage 1 data SHALL be all zeros and err SHALL be 1 when valido_in=1.
REQ-019 When valido_in=0 and the pipeline advances, stage 1 valid and err SHALL load 0. Data SHALL load the mux result, since it is a don't-care.
REQ-020 stall=1 (with flush=0) SHALL hold every stage register unchanged. Inputs presented during stall SHALL be dropped.
REQ-021 flush=1 SHALL clear valid and err in every stage and set every data register to 0 at the next edge.
REQ-022 flush SHALL take priority over stall when both are asserted.
REQ-023 flush SHALL also discard the input presented in the same cycle.
REQ-024 error_sel SHALL only be 1 while valido_out=1.
REQ-025 Back-to-back valid inputs SHALL be accepted every cycle, giving throughput of one per cycle with no bubbles inserted.
REQ-026 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-027 While rst_n=0, every stage SHALL hold data=0, valid=0, err=0 immediately, independent of clk.
REQ-028 Resulting output values during reset: salida=0, valido_out=0, error_sel=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries.
REQ-030 After rst_n deasserts, the first capture SHALL occur on the first rising edge with rst_n=1.

Verification
REQ-031 ENTRADAS=4, ETAPAS=1; sel=2, entradas={D3,D2=32'hA5A5_0001,D1,D0}, valido_in=1 for one cycle -> next cycle salida=32'hA5A5_0001, valido_out=1, error_sel=0; the cycle after, valido_out=0.
REQ-032 ENTRADAS=3, ETAPAS=2; sel=3, valido_in=1 -> two cycles later salida=0, valido_out=1, error_sel=1.
REQ-033 ETAPAS=2; valid entries X then Y on consecutive cycles, stall=1 for 3 cycles after Y enters -> salida holds X for 3 cycles, then Y appears on the first cycle after stall drops.
REQ-034 ETAPAS=2; two entries in flight, stall=1 and flush=1 in the same cycle -> next edge valido_out=0, salida=0, and no later valid output appears.
REQ-035 ETAPAS=1; valid stream running, rst_n pulsed low between edges -> salida=0 and valido_out=0 immediately; the first input after release appears one cycle later.
REQ-036 ENTRADAS=2, ETAPAS=1; sel toggles 0,1,0,1 with valido_in=1 and entradas={32'h1,32'h2} -> salida=2,1,2,1 on consecutive cycles with no gaps.
